debug_uart_rx: RTL and testbench
================================

// Module: debug_uart_rx
// PURPOSE
//  Debug UART receiver that sits directly downstream of the debug auto-baud detector.
//  - Consumes its divisor write (baud_wr/baud_div) and selected-input code (rx_sel).
//  - Builds a 16x oversample tick, samples the chosen RX line and deframes 8N1 bytes.
//  - Presents each byte on a one-entry valid/ready output register for the debug command parser.
// PARAMETERS
//  SYNC_STAGES  2   synchronizer flops per RX input, min 2
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous reset, active-high
//  baud_wr    in   1  1-cycle strobe: latch baud_div
//  baud_div   in   8  bit period in units of 32 clk (bit time = 32*baud_div clk)
//  rx_sel     in   2  1/2/3 selects rx1/rx2/rx3; 0 = none (line treated idle-high)
//  rx1        in   1  async RX candidate 1
//  rx2        in   1  async RX candidate 2
//  rx3        in   1  async RX candidate 3
//  rx_data    out  8  received byte, stable while rx_valid=1
//  rx_valid   out  1  byte available
//  rx_ready   in   1  consumer accepts byte when rx_valid&rx_ready
//  frm_err    out  1  1-cycle pulse: stop bit sampled low
//  ovr_err    out  1  1-cycle pulse: byte dropped, holding reg full
// BEHAVIOUR
//  Reset (rst=1 at clk edge): div_q=0, prescaler=0, state=IDLE, sync flops=1,
//   rx_data=0, rx_valid=0, frm_err=0, ovr_err=0. Reset mid-frame discards the frame.
//  Sync: each rxN passes SYNC_STAGES flops; mux selects after sync; rx_sel=0 -> 1.
//  Prescaler: 9-bit down-counter; tick=1 for one clk when it is 0 and div_q!=0, then
//   reloads {div_q,1'b0}-1 (tick period 2*div_q clk). div_q=0 -> no ticks, FSM held IDLE.
//  baud_wr: div_q<=baud_div, prescaler<=0, FSM forced to IDLE (frame aborted, no pulses).
//  rx_sel change (vs. registered copy) while FSM != IDLE: abort to IDLE, no pulses.
//  FSM (tcnt = 4-bit tick counter, bcnt = 3-bit bit index, shreg = 8-bit shift):
//   IDLE: synced line==0 -> START, tcnt=0 (edge sampled every clk, not on tick).
//   START: on tick tcnt++; at 8th tick sample: 0 -> DATA, tcnt=0, bcnt=0;
//    1 -> IDLE (glitch rejected). Line returning high earlier does not abort before the sample.
//   DATA: on tick tcnt++; at 16th tick sample into shreg MSB, shift right (LSB first);
//    bcnt==7 -> STOP.
//   STOP: at 16th tick sample: 1 -> deliver, IDLE; 0 -> frm_err pulse, byte discarded, WAIT_HI.
//   WAIT_HI: stay until synced line==1 (break/stuck-low), then IDLE.
//  Deliver (cycle after stop sample): if rx_valid==0 or (rx_valid&rx_ready) that cycle:
//   rx_data<=shreg, rx_valid<=1. Otherwise ovr_err pulse, old byte kept, new byte dropped.
//  rx_valid clears the cycle after rx_valid&rx_ready unless a deliver coincides (then stays 1,
//   data updates). rx_data never changes while rx_valid=1 and rx_ready=0.
//  Latency: rx_valid rises 1 clk after the stop-bit sampling tick.
//  frm_err and ovr_err are mutually exclusive per frame; each is high exactly 1 clk.
// TESTING
//  T1 div=4 (bit=128 clk), rx_sel=2, send 0x55 on rx2, rx_ready=1 -> rx_valid 1 clk,
//     rx_data=0x55; rx1/rx3 toggling ignored.
//  T2 div=4, rx_sel=1, 3-clk low glitch on rx1 -> no rx_valid, no errors, FSM back IDLE.
//  T3 div=4, send 0xA3 with stop bit low -> frm_err 1 clk, rx_valid stays 0; line held low
//     512 clk then high -> next byte 0x3C received correctly.
//  T4 rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 held, ovr_err 1 clk at second stop;
//     rx_ready=1 -> rx_valid drops next clk.
//  T5 baud_div=0 or rx_sel=0, drive frames -> no rx_valid, no errors ever.
//  T6 rst=1 mid-DATA of 0xF0, then release and send 0x0F -> only 0x0F delivered;
//     baud_wr mid-frame likewise aborts with no pulses.

Source files
------------

// File: rtl/debug_uart_rx.sv
// Debug UART receiver: synchronizes the selected RX line, oversamples it 16x per bit
// and deframes 8N1 bytes into a one-entry valid/ready holding register.
module debug_uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_wr,
  input  logic [7:0] baud_div,
  input  logic [1:0] rx_sel,
  input  logic       rx1,
  input  logic       rx2,
  input  logic       rx3,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frm_err,
  output logic       ovr_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HI
  } state_e;

  logic [2:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [7:0] div_q, div_d;
  logic [8:0] presc_q, presc_d;
  state_e     state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frm_err_q, frm_err_d;
  logic       ovr_err_q, ovr_err_d;

  logic [2:0] rx_in;
  logic       rx_line;
  logic       tick;
  logic       abort;
  logic       deliver;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    rx_in = {rx3, rx2, rx1};
    for (int i = 0; i < 3; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], rx_in[i]};
    end

    case (rx_sel)
      2'd1:    rx_line = sync_q[0][SYNC_STAGES-1];
      2'd2:    rx_line = sync_q[1][SYNC_STAGES-1];
      2'd3:    rx_line = sync_q[2][SYNC_STAGES-1];
      default: rx_line = 1'b1;
    endcase

    tick    = (presc_q == 9'd0) && (div_q != 8'd0);
    div_d   = div_q;
    presc_d = presc_q;
    if (tick) begin
      presc_d = {div_q, 1'b0} - 9'd1;
    end else if (presc_q != 9'd0) begin
      presc_d = presc_q - 9'd1;
    end
    if (baud_wr) begin
      div_d   = baud_div;
      presc_d = 9'd0;
    end

    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    shreg_d   = shreg_q;
    sel_d     = rx_sel;
    frm_err_d = 1'b0;
    ovr_err_d = 1'b0;
    deliver   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_line) begin
          state_d = S_START;
          tcnt_d  = 4'd0;
        end
      end
      S_START: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd7) begin
            tcnt_d  = 4'd0;
            bcnt_d  = 3'd0;
            state_d = rx_line ? S_IDLE : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            shreg_d = {rx_line, shreg_q[7:1]};
            bcnt_d  = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            if (rx_line) begin
              deliver = 1'b1;
              state_d = S_IDLE;
            end else begin
              frm_err_d = 1'b1;
              state_d   = S_WAIT_HI;
            end
          end
        end
      end
      S_WAIT_HI: begin
        if (rx_line) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Divisor writes, a dead divisor or a mid-frame input switch drop the frame silently.
    abort = baud_wr || (div_q == 8'd0) || ((state_q != S_IDLE) && (rx_sel != sel_q));
    if (abort) begin
      state_d   = S_IDLE;
      deliver   = 1'b0;
      frm_err_d = 1'b0;
    end

    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q && !rx_ready;
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        ovr_err_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '1;
      div_q      <= 8'd0;
      presc_q    <= 9'd0;
      state_q    <= S_IDLE;
      tcnt_q     <= 4'd0;
      bcnt_q     <= 3'd0;
      shreg_q    <= 8'd0;
      sel_q      <= 2'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      frm_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      div_q      <= div_d;
      presc_q    <= presc_d;
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bcnt_q     <= bcnt_d;
      shreg_q    <= shreg_d;
      sel_q      <= sel_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      frm_err_q  <= frm_err_d;
      ovr_err_q  <= ovr_err_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign frm_err  = frm_err_q;
  assign ovr_err  = ovr_err_q;

endmodule

// File: tb/tb_debug_uart_rx.sv
// Self-checking bench for debug_uart_rx: frame-level reference model (expected byte
// queue and error counts) against a handshake monitor, plus directed corner sequences.
module tb_debug_uart_rx;

  localparam int BIT_CLKS = 128;  // 32 * divisor 4

  logic       clk = 1'b0;
  logic       rst, baud_wr;
  logic [7:0] baud_div;
  logic [1:0] rx_sel;
  logic       rx1, rx2, rx3;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, frm_err, ovr_err;

  logic       tx;
  logic [1:0] tx_line;
  logic       noise_en;
  logic [2:0] noise   = 3'b111;
  logic       rdy_rnd = 1'b0;
  logic       rdy_rand, rdy_fix;

  int errors = 0;
  int checks = 0;
  logic [7:0] got[$];
  int n_frm = 0, n_ovr = 0, n_vcyc = 0, width_viol = 0, hold_viol = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [1:0] line;
    int         exp_cnt;
    int         exp_frm;
  } vec_t;

  always #5 clk = ~clk;

  assign rx1      = (tx_line == 2'd1) ? tx : (noise_en ? noise[0] : 1'b1);
  assign rx2      = (tx_line == 2'd2) ? tx : (noise_en ? noise[1] : 1'b1);
  assign rx3      = (tx_line == 2'd3) ? tx : (noise_en ? noise[2] : 1'b1);
  assign rx_ready = rdy_rand ? rdy_rnd : rdy_fix;

  debug_uart_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .baud_wr(baud_wr), .baud_div(baud_div), .rx_sel(rx_sel),
    .rx1(rx1), .rx2(rx2), .rx3(rx3), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frm_err(frm_err), .ovr_err(ovr_err)
  );

  initial forever begin
    @(posedge clk);
    #1;
    noise   = 3'($urandom);
    rdy_rnd = 1'($urandom);
  end

  logic       prev_v = 1'b0, prev_r = 1'b0, prev_f = 1'b0, prev_o = 1'b0;
  logic [7:0] prev_d = 8'd0;
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (rx_valid) n_vcyc++;
      if (frm_err) n_frm++;
      if (ovr_err) n_ovr++;
      if ((frm_err && prev_f) || (ovr_err && prev_o) || (frm_err && ovr_err)) width_viol++;
      if (prev_v && !prev_r && (!rx_valid || rx_data != prev_d)) hold_viol++;
    end
    prev_v = rx_valid; prev_r = rx_ready; prev_d = rx_data;
    prev_f = frm_err;  prev_o = ovr_err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] got_at(input int i);
    if (i >= 0 && i < got.size()) return got[i];
    return 8'hxx;
  endfunction

  task automatic clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_div(input logic [7:0] d);
    baud_div = d;
    baud_wr  = 1'b1;
    clks(1);
    baud_wr  = 1'b0;
  endtask

  task automatic use_line(input logic [1:0] l);
    tx_line = l;
    rx_sel  = l;
    clks(100);
  endtask

  // Drives the first nbits of {stop, data, start} LSB first, then returns the line high.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int nbits);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      tx = bits[i];
      clks(BIT_CLKS);
    end
    tx = 1'b1;
  endtask

  vec_t vecs[6];
  logic [7:0] exp_q[$];
  int base, f0, o0, v0, exp_frm;

  initial begin
    rst = 1'b1; baud_wr = 1'b0; baud_div = 8'd0; rx_sel = 2'd0;
    tx = 1'b1; tx_line = 2'd0; noise_en = 1'b0; rdy_rand = 1'b0; rdy_fix = 1'b1;
    clks(3);
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_data", rx_data, 0);
    check("reset frm_err", frm_err, 0);
    check("reset ovr_err", ovr_err, 0);
    rst = 1'b0;
    clks(2);

    // T1: 0x55 on rx2 while rx1/rx3 toggle
    write_div(8'd4);
    noise_en = 1'b1;
    use_line(2'd2);
    base = got.size(); v0 = n_vcyc; f0 = n_frm; o0 = n_ovr;
    send_frame(8'h55, 1'b1, 10);
    clks(200);
    check("t1 count", got.size() - base, 1);
    check("t1 data", got_at(base), 8'h55);
    check("t1 valid cycles", n_vcyc - v0, 1);
    check("t1 errors", (n_frm - f0) + (n_ovr - o0), 0);

    // T2: short low glitch rejected, receiver still usable afterwards
    use_line(2'd1);
    base = got.size(); f0 = n_frm; o0 = n_ovr;
    tx = 1'b0;
    clks(3);
    tx = 1'b1;
    clks(300);
    check("t2 glitch bytes", got.size() - base, 0);
    check("t2 glitch errors", (n_frm - f0) + (n_ovr - o0), 0);
    send_frame(8'hC5, 1'b1, 10);
    clks(150);
    check("t2 after glitch", got_at(got.size() - 1), 8'hC5);

    // Table of single frames with a randomly stalling consumer
    vecs[0] = '{8'h00, 1'b1, 2'd1, 1, 0};
    vecs[1] = '{8'hFF, 1'b1, 2'd2, 1, 0};
    vecs[2] = '{8'h80, 1'b1, 2'd3, 1, 0};
    vecs[3] = '{8'h01, 1'b1, 2'd1, 1, 0};
    vecs[4] = '{8'hA3, 1'b0, 2'd2, 0, 1};
    vecs[5] = '{8'h7E, 1'b1, 2'd3, 1, 0};
    rdy_rand = 1'b1;
    for (int i = 0; i < 6; i++) begin
      use_line(vecs[i].line);
      base = got.size(); f0 = n_frm;
      send_frame(vecs[i].data, vecs[i].stop, 10);
      clks(150);
      check($sformatf("vec%0d count", i), got.size() - base, vecs[i].exp_cnt);
      check($sformatf("vec%0d frm", i), n_frm - f0, vecs[i].exp_frm);
      if (vecs[i].exp_cnt == 1) check($sformatf("vec%0d data", i), got_at(base), vecs[i].data);
    end
    rdy_rand = 1'b0;

    // T3: bad stop, line held low, then recovery
    use_line(2'd1);
    base = got.size(); f0 = n_frm; v0 = n_vcyc;
    send_frame(8'hA3, 1'b0, 9);
    tx = 1'b0;
    clks(BIT_CLKS + 512);
    check("t3 frm pulses", n_frm - f0, 1);
    check("t3 no valid", n_vcyc - v0, 0);
    tx = 1'b1;
    clks(100);
    send_frame(8'h3C, 1'b1, 10);
    clks(150);
    check("t3 recovered count", got.size() - base, 1);
    check("t3 recovered data", got_at(base), 8'h3C);

    // T4: overrun with a stalled consumer
    rdy_fix = 1'b0;
    base = got.size(); f0 = n_frm; o0 = n_ovr;
    send_frame(8'h11, 1'b1, 10);
    send_frame(8'h22, 1'b1, 10);
    clks(100);
    check("t4 valid held", rx_valid, 1);
    check("t4 data held", rx_data, 8'h11);
    check("t4 ovr pulses", n_ovr - o0, 1);
    check("t4 frm pulses", n_frm - f0, 0);
    rdy_fix = 1'b1;
    clks(1);
    check("t4 valid drop", rx_valid, 0);
    check("t4 consumed", got_at(base), 8'h11);
    check("t4 consumed count", got.size() - base, 1);

    // T5: no divisor, then no selected input
    base = got.size(); f0 = n_frm; o0 = n_ovr;
    write_div(8'd0);
    send_frame(8'h5A, 1'b1, 10);
    clks(100);
    write_div(8'd4);
    rx_sel = 2'd0;
    clks(100);
    send_frame(8'h5A, 1'b1, 10);
    clks(100);
    check("t5 bytes", got.size() - base, 0);
    check("t5 errors", (n_frm - f0) + (n_ovr - o0), 0);
    use_line(2'd1);

    // T6: reset mid-frame, then baud_wr mid-frame
    send_frame(8'hF0, 1'b1, 3);
    rst = 1'b1;
    clks(2);
    check("t6 reset data", rx_data, 0);
    check("t6 reset valid", rx_valid, 0);
    rst = 1'b0;
    write_div(8'd4);
    clks(100);
    base = got.size(); f0 = n_frm; o0 = n_ovr;
    send_frame(8'h0F, 1'b1, 10);
    clks(150);
    check("t6 rst count", got.size() - base, 1);
    check("t6 rst data", got_at(base), 8'h0F);
    base = got.size();
    send_frame(8'hF0, 1'b1, 3);
    write_div(8'd4);
    clks(300);
    send_frame(8'h0F, 1'b1, 10);
    clks(150);
    check("t6 wr count", got.size() - base, 1);
    check("t6 wr data", got_at(base), 8'h0F);
    check("t6 errors", (n_frm - f0) + (n_ovr - o0), 0);

    // Randomized frames against the frame-level model
    rdy_rand = 1'b1;
    base = got.size(); f0 = n_frm; o0 = n_ovr; exp_frm = 0;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      logic       s;
      b = 8'($urandom);
      s = ($urandom_range(0, 4) != 0);
      use_line(2'($urandom_range(1, 3)));
      if (s) exp_q.push_back(b);
      else exp_frm++;
      send_frame(b, s, 10);
      clks($urandom_range(0, 64));
    end
    clks(200);
    check("rand count", got.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("rand byte%0d", i), got_at(base + i), exp_q[i]);
    end
    check("rand frm", n_frm - f0, exp_frm);
    check("rand ovr", n_ovr - o0, 0);

    check("pulse width/exclusive", width_viol, 0);
    check("data stable while stalled", hold_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
